// File: rtl/bf_input_conditioner_if.sv
// CPU-facing link of the input conditioner: debug view inputs plus the
// start/halt/run controls and the registered debug byte driven back to the board.
interface bf_input_conditioner_if #(
    parameter int ADDR_W      = 4,
    parameter int TAPE_ADDR_W = 3
);
    logic [1:0]             dbg_sel_i;
    logic [ADDR_W-1:0]      pc_i;
    logic [TAPE_ADDR_W-1:0] dp_i;
    logic [7:0]             cell_i;
    logic                   busy_i;
    logic                   start_o;
    logic                   halt_o;
    logic                   running_o;
    logic [7:0]             dbg_o;

    modport master (
        input  dbg_sel_i, pc_i, dp_i, cell_i, busy_i,
        output start_o, halt_o, running_o, dbg_o
    );

    modport slave (
        output dbg_sel_i, pc_i, dp_i, cell_i, busy_i,
        input  start_o, halt_o, running_o, dbg_o
    );
endinterface

// File: rtl/bf_input_conditioner.sv
// Board front end for TinyBF: synchronises and debounces start/halt buttons into
// one-cycle pulses, tracks the run flag and presents a registered debug byte.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | CPU not started, or stopped by a halt pulse
// ST_RUN  | start pulse issued since the last halt pulse
module bf_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ADDR_W          = 4,
    parameter int TAPE_ADDR_W     = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_btn_i,
    input  logic                   halt_btn_i,
    bf_input_conditioner_if.master cpu
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit 0 carries the start button, bit 1 the halt button.
    logic [1:0]             btn;
    logic [1:0]             sync1;
    logic [1:0]             sync2;
    logic [1:0]             stable;
    logic [1:0]             prev;
    logic [1:0]             raw;
    logic [CNT_W-1:0]       cnt [2];
    state_t                 state;
    state_t                 state_next;
    logic                   start_q;
    logic                   halt_q;
    logic                   running;
    logic [7:0]             dbg_q;
    logic [7:0]             dbg_next;
    logic [ADDR_W-1:0]      pc;
    logic [TAPE_ADDR_W-1:0] dp;

    assign btn = {halt_btn_i, start_btn_i};
    assign pc  = cpu.pc_i;
    assign dp  = cpu.dp_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Any sample agreeing with the stable level restarts the count, so the
    // counter tops out at CNT_TC and never wraps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stable <= '0;
            for (int b = 0; b < 2; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != stable[b]) begin
                    if (cnt[b] == CNT_TC) begin
                        stable[b] <= sync2[b];
                        cnt[b]    <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + 1'b1;
                    end
                end else begin
                    cnt[b] <= '0;
                end
            end
        end
    end

    assign raw = stable & ~prev;

    // Halt wins a same-cycle collision; the colliding start is discarded.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev    <= '0;
            start_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            prev    <= stable;
            start_q <= raw[0] & ~raw[1];
            halt_q  <= raw[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (raw[1]) begin
            state_next = ST_IDLE;
        end else if (raw[0]) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    always_comb begin
        dbg_next = '0;
        unique case (cpu.dbg_sel_i)
            2'd0:    dbg_next = 8'(pc);
            2'd1:    dbg_next = 8'(dp);
            2'd2:    dbg_next = cpu.cell_i;
            default: dbg_next = {cpu.busy_i, running, stable[0], stable[1], 4'b0000};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_next;
        end
    end

    assign cpu.start_o   = start_q;
    assign cpu.halt_o    = halt_q;
    assign cpu.running_o = running;
    assign cpu.dbg_o     = dbg_q;

endmodule

// File: tb/tb_bf_input_conditioner.sv
// Scoreboard bench for bf_input_conditioner: a cycle-level reference model queues
// expected pulses, a monitor checks pulses, run flag and debug byte every cycle.
module tb_bf_input_conditioner;

    localparam int N = 4;

    typedef struct {
        int cyc;
        bit is_halt;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_btn;
    logic halt_btn;
    bit   rnd_dbg;

    int errors = 0;
    int checks = 0;

    bf_input_conditioner_if #(.ADDR_W(4), .TAPE_ADDR_W(3)) cpu_if ();

    bf_input_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .ADDR_W(4),
        .TAPE_ADDR_W(3)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .start_btn_i(start_btn),
        .halt_btn_i (halt_btn),
        .cpu        (cpu_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the synchronised pin has
    // disagreed with the accepted level for N consecutive cycles; a newly
    // accepted press shows up as a pulse on the following edge.
    ev_t      q[$];
    int       cyc;
    bit [1:0] m_s1, m_s2, m_stb;
    int       run_len [2];
    bit       m_running, pend_start, pend_halt;
    bit [7:0] dbg_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            m_s1 = '0; m_s2 = '0; m_stb = '0;
            run_len[0] = 0; run_len[1] = 0;
            m_running = 0; pend_start = 0; pend_halt = 0;
            dbg_exp = '0;
            q.delete();
        end else begin
            bit [1:0] rose;
            cyc++;
            case (cpu_if.dbg_sel_i)
                2'd0: dbg_exp = {4'b0, cpu_if.pc_i};
                2'd1: dbg_exp = {5'b0, cpu_if.dp_i};
                2'd2: dbg_exp = cpu_if.cell_i;
                default: dbg_exp = {cpu_if.busy_i, m_running, m_stb[0], m_stb[1], 4'b0};
            endcase
            if (pend_halt) m_running = 0;
            else if (pend_start) m_running = 1;
            pend_start = 0;
            pend_halt  = 0;
            rose = '0;
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_stb[b]) begin
                    run_len[b]++;
                    if (run_len[b] == N) begin
                        m_stb[b]   = m_s2[b];
                        run_len[b] = 0;
                        rose[b]    = m_stb[b];
                    end
                end else begin
                    run_len[b] = 0;
                end
            end
            if (rose[1]) begin
                q.push_back('{cyc + 1, 1'b1});
                pend_halt = 1;
            end else if (rose[0]) begin
                q.push_back('{cyc + 1, 1'b0});
                pend_start = 1;
            end
            m_s2 = m_s1;
            m_s1 = {halt_btn, start_btn};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                chk("rst_start_o", cpu_if.start_o, 0);
                chk("rst_halt_o", cpu_if.halt_o, 0);
                chk("rst_running_o", cpu_if.running_o, 0);
                chk("rst_dbg_o", cpu_if.dbg_o, 0);
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_missing: got none expected %s pulse at cycle %0d",
                             q[0].is_halt ? "halt" : "start", q[0].cyc);
                    void'(q.pop_front());
                end
                if (cpu_if.start_o || cpu_if.halt_o) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pulse_spurious: got start=%0b halt=%0b expected none at cycle %0d",
                                 cpu_if.start_o, cpu_if.halt_o, cyc);
                    end else begin
                        ev_t e;
                        e = q.pop_front();
                        chk("pulse_cycle", cyc, e.cyc);
                        chk("pulse_kind_halt", cpu_if.halt_o, e.is_halt);
                        chk("pulse_exclusive", cpu_if.start_o & cpu_if.halt_o, 0);
                    end
                end
                chk("running_o", cpu_if.running_o, m_running);
                chk("dbg_o", cpu_if.dbg_o, dbg_exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rnd_dbg) begin
                cpu_if.dbg_sel_i = 2'($urandom_range(0, 3));
                cpu_if.pc_i      = 4'($urandom);
                cpu_if.dp_i      = 3'($urandom);
                cpu_if.cell_i    = 8'($urandom);
                cpu_if.busy_i    = 1'($urandom);
            end
        end
    endtask

    // Counts edges from the first one sampling a new pin level to start_o.
    task automatic measure_start_latency(input string name);
        int lat;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (cpu_if.start_o) begin
                lat = i;
                break;
            end
        end
        chk(name, lat, N + 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start_btn = 1'b0;
        halt_btn = 1'b0;
        rnd_dbg = 1'b1;
        cpu_if.dbg_sel_i = 2'd0;
        cpu_if.pc_i = '0;
        cpu_if.dp_i = '0;
        cpu_if.cell_i = '0;
        cpu_if.busy_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step(5);

        // Clean press, held 20 cycles, then release
        start_btn = 1'b1;
        measure_start_latency("clean_latency");
        @(posedge clk);
        #1;
        chk("clean_single_cycle", cpu_if.start_o, 0);
        step(12);
        start_btn = 1'b0;
        step(15);

        // Bounce 1,0,1,0 at two cycles each, then steady press
        for (int i = 0; i < 4; i++) begin
            start_btn = (i % 2 == 0);
            step(2);
        end
        start_btn = 1'b1;
        measure_start_latency("bounce_latency");
        step(10);
        start_btn = 1'b0;
        step(15);

        // Simultaneous press: halt wins
        start_btn = 1'b1;
        halt_btn = 1'b1;
        step(15);
        chk("simul_running", cpu_if.running_o, 0);
        start_btn = 1'b0;
        halt_btn = 1'b0;
        step(15);

        // Start, halt 30 cycles later, start again
        start_btn = 1'b1;
        step(10);
        chk("seq_running_set", cpu_if.running_o, 1);
        start_btn = 1'b0;
        step(20);
        halt_btn = 1'b1;
        step(10);
        chk("seq_running_clr", cpu_if.running_o, 0);
        halt_btn = 1'b0;
        step(10);
        start_btn = 1'b1;
        step(10);
        start_btn = 1'b0;
        step(15);
        chk("seq_running_again", cpu_if.running_o, 1);

        // Debug mux sweep with fixed CPU view
        rnd_dbg = 1'b0;
        cpu_if.pc_i = 4'hA;
        cpu_if.dp_i = 3'h5;
        cpu_if.cell_i = 8'h3C;
        cpu_if.busy_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bit [7:0] want;
            @(negedge clk);
            cpu_if.dbg_sel_i = 2'(s);
            want = (s == 0) ? 8'h0A : (s == 1) ? 8'h05 : (s == 2) ? 8'h3C : 8'hC0;
            @(posedge clk);
            #1;
            chk($sformatf("dbg_sel%0d", s), cpu_if.dbg_o, want);
        end
        rnd_dbg = 1'b1;
        step(3);

        // Reset while start_o is high, button held through release
        start_btn = 1'b1;
        measure_start_latency("pre_reset_latency");
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_cut_start", cpu_if.start_o, 0);
        chk("reset_cut_running", cpu_if.running_o, 0);
        chk("reset_cut_dbg", cpu_if.dbg_o, 0);
        step(3);
        rst_n = 1'b1;
        measure_start_latency("post_reset_latency");
        step(5);
        start_btn = 1'b0;
        step(15);

        // Random button activity with bounces of varying length
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 4) == 0) halt_btn = ~halt_btn;
            step($urandom_range(1, 9));
        end
        start_btn = 1'b0;
        halt_btn = 1'b0;
        step(20);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
